// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: default divider widths and the divider FSM encoding.
package arith_pkg;
    localparam int DVD_W = 20;
    localparam int DVS_W = 4;
    localparam int QUO_W = DVD_W - DVS_W;
    localparam int CNT_W = $clog2(QUO_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, and produce the quotient bit.
module div_step #(
    parameter int DVS_W = 4,
    parameter int QUO_W = 16
) (
    input  logic [DVS_W:0]   r_i,
    input  logic [QUO_W-1:0] q_i,
    input  logic [DVS_W-1:0] d_i,
    output logic [DVS_W:0]   r_o,
    output logic [QUO_W-2:0] q_hi_o,
    output logic             q_bit_o
);
    logic [DVS_W+1:0] r_sh;

    // Full-width shifted remainder so the compare never loses the top bit.
    assign r_sh    = {r_i, q_i[QUO_W-1]};
    assign q_bit_o = (r_sh >= (DVS_W+2)'(d_i));
    assign r_o     = q_bit_o ? (DVS_W+1)'(r_sh - (DVS_W+2)'(d_i)) : r_sh[DVS_W:0];
    assign q_hi_o  = q_i[QUO_W-2:0];
endmodule

// File: rtl/unsigned_divider.sv
// Sequential restoring divider (DVD_W / DVS_W -> QUO_W quotient, DVS_W remainder), one bit per clock.
// Optional DIV_ABORT_EN adds an Abort input that cancels a division in progress.
module unsigned_divider
    import arith_pkg::*;
#(
    parameter int DVD_W = arith_pkg::DVD_W,
    parameter int DVS_W = arith_pkg::DVS_W,
    parameter int QUO_W = DVD_W - DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             St,
`ifdef DIV_ABORT_EN
    input  logic             Abort,
`endif
    input  logic [DVD_W-1:0] Dividend,
    input  logic [DVS_W-1:0] Divisor,
    output logic [QUO_W-1:0] Quotient,
    output logic [DVS_W-1:0] Remainder,
    output logic             Done,
    output logic             V
);
    localparam int CW = $clog2(QUO_W + 1);

    div_state_e       state_q, state_d;
    logic [DVS_W:0]   r_q, r_d;
    logic [QUO_W-1:0] q_q, q_d;
    logic [DVS_W-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [QUO_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             v_q, v_d;

    logic [DVS_W:0]   step_r;
    logic [QUO_W-2:0] step_q_hi;
    logic             step_bit;
    logic             start_ovf;

    div_step #(.DVS_W(DVS_W), .QUO_W(QUO_W)) u_step (
        .r_i    (r_q),
        .q_i    (q_q),
        .d_i    (d_q),
        .r_o    (step_r),
        .q_hi_o (step_q_hi),
        .q_bit_o(step_bit)
    );

    // Quotient would not fit in QUO_W bits; Divisor==0 falls out of the same compare.
    assign start_ovf = (Dividend[DVD_W-1:QUO_W] >= Divisor);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        v_d     = v_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (St) begin
                    d_d   = Divisor;
                    cnt_d = '0;
                    ovf_d = start_ovf;
                    if (start_ovf) begin
                        r_d     = '0;
                        q_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        r_d     = {1'b0, Dividend[DVD_W-1:QUO_W]};
                        q_d     = Dividend[QUO_W-1:0];
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
`ifdef DIV_ABORT_EN
                if (Abort) begin
                    state_d = S_IDLE;
                end else
`endif
                begin
                    r_d   = step_r;
                    q_d   = {step_q_hi, step_bit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(QUO_W - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                quo_d   = q_q;
                rem_d   = r_q[DVS_W-1:0];
                v_d     = ovf_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            v_q     <= v_d;
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign Done      = done_q;
    assign V         = v_q;
endmodule

// File: tb/tb_unsigned_divider.sv
// Scoreboard bench for unsigned_divider: directed divides push expected results, a monitor checks each Done.
module tb_unsigned_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        St = 1'b0;
    logic [19:0] Dividend = '0;
    logic [3:0]  Divisor = '0;
    logic [15:0] Quotient;
    logic [3:0]  Remainder;
    logic        Done;
    logic        V;
`ifdef DIV_ABORT_EN
    logic        Abort = 1'b0;
`endif

    typedef struct {
        logic [15:0] q;
        logic [3:0]  r;
        logic        v;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic done_prev = 1'b0;

    unsigned_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .St       (St),
`ifdef DIV_ABORT_EN
        .Abort    (Abort),
`endif
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Done     (Done),
        .V        (V)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && Done) begin
            chk("done_pulse_width", int'(done_prev), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", int'(Quotient), int'(e.q));
                chk("remainder", int'(Remainder), int'(e.r));
                chk("overflow_v", int'(V), int'(e.v));
                chk("done_latency", cyc, e.cyc);
            end
        end
        done_prev <= Done;
    end

    task automatic start(input logic [19:0] dvd, input logic [3:0] dvs, input bit push,
                         input logic [15:0] eq, input logic [3:0] er, input logic ev);
        @(posedge clk); #1;
        Dividend = dvd;
        Divisor  = dvs;
        St       = 1'b1;
        if (push) sb.push_back('{eq, er, ev, cyc + 1 + (ev ? 1 : 17)});
        @(posedge clk); #1;
        St = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset with garbage on the inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            St       = 1'($urandom);
            Dividend = 20'($urandom);
            Divisor  = 4'($urandom);
        end
        @(negedge clk);
        chk("reset_quotient", int'(Quotient), 0);
        chk("reset_remainder", int'(Remainder), 0);
        chk("reset_done", int'(Done), 0);
        chk("reset_v", int'(V), 0);
        St = 1'b0;
        rst_n = 1'b1;

        start(20'd45, 4'd5, 1, 16'd9, 4'd0, 1'b0);    drain();
        start(20'd165, 4'd15, 1, 16'd11, 4'd0, 1'b0); drain();
        start(20'd166, 4'd15, 1, 16'd11, 4'd1, 1'b0); drain();

        // St held high: two back-to-back divides, operands disturbed while busy.
        @(posedge clk); #1;
        n = cyc;
        Dividend = 20'd165;
        Divisor  = 4'd15;
        St       = 1'b1;
        sb.push_back('{16'd11, 4'd0, 1'b0, n + 18});
        sb.push_back('{16'd11, 4'd1, 1'b0, n + 36});
        repeat (4) @(posedge clk);
        #1 Dividend = 20'd166;
        repeat (16) @(posedge clk);
        #1 Dividend = 20'd45;
        Divisor = 4'd5;
        St = 1'b0;
        drain();

        // Overflow, V held in IDLE, divide by zero, then V cleared.
        start(20'h50000, 4'd5, 1, 16'd0, 4'd0, 1'b1); drain();
        repeat (5) @(negedge clk);
        chk("v_held_idle", int'(V), 1);
        chk("q_held_idle", int'(Quotient), 0);
        start(20'd1234, 4'd0, 1, 16'd0, 4'd0, 1'b1);  drain();
        start(20'd45, 4'd5, 1, 16'd9, 4'd0, 1'b0);    drain();

        start(20'hEFFFF, 4'd15, 1, 16'd65535, 4'd14, 1'b0); drain();
        start(20'hFFFFF, 4'd15, 1, 16'd0, 4'd0, 1'b1);      drain();

        // Reset at iteration 8: no Done, outputs back to reset values.
        start(20'd166, 4'd15, 1, 16'd11, 4'd1, 1'b0); drain();
        start(20'd45, 4'd5, 0, 16'd0, 4'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midop_reset_quotient", int'(Quotient), 0);
        chk("midop_reset_remainder", int'(Remainder), 0);
        chk("midop_reset_v", int'(V), 0);
        chk("midop_reset_done", int'(Done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        start(20'd100, 4'd7, 1, 16'd14, 4'd2, 1'b0); drain();

`ifdef DIV_ABORT_EN
        start(20'd45, 4'd5, 0, 16'd0, 4'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1 Abort = 1'b1;
        @(posedge clk); #1 Abort = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_quotient_held", int'(Quotient), 14);
        chk("abort_remainder_held", int'(Remainder), 2);
        chk("abort_v_held", int'(V), 0);
        start(20'd165, 4'd15, 1, 16'd11, 4'd0, 1'b0); drain();
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
